stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose
//   Multi-cycle instruction sequencer. It walks each instruction through
//   FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK and then returns to FETCH.
//   It keeps the program counter and a saturating count of retired
//   instructions. An endProgram request seen in DECODE parks the sequencer
//   in HALT. Only reset leaves HALT.
//
// Optional feature
//   STAGE_SEQUENCER_MEM_SKIP_EN : when defined, an instruction that makes no
//   memory request in EXECUTE goes straight to WRITEBACK (4-cycle
//   instruction). When undefined, every instruction passes through MEMORY
//   for at least one cycle.
//
// Handshake semantics
//   start is a level sampled only in IDLE: the first rising edge that sees
//   start=1 begins execution. In MEMORY, a pending request
//   (memRead|memWrite) completes on the first edge where memReady=1. The
//   state is held with no timeout until then. With no request, MEMORY is
//   left on the next edge.
//
// Ports
//   clock, reset_n      : single clock, asynchronous active-low reset
//   start               : begin execution (IDLE only)
//   endProgram          : halt request (DECODE only)
//   branch, zero        : branch condition inputs (EXECUTE only)
//   branchOffset        : signed PC offset (EXECUTE only)
//   memRead, memWrite   : memory request (MEMORY; also EXECUTE with skip)
//   memReady            : memory access complete
//   stage1..stage5      : registered one-hot stage enables
//   pc                  : current instruction address
//   busy                : high in FETCH..WRITEBACK
//   halted              : high in HALT
//   instrCount          : retired instruction count, saturating
//   state_dbg           : current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int PC_WIDTH  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 endProgram,
    input  logic                 branch,
    input  logic                 zero,
    input  logic [PC_WIDTH-1:0]  branchOffset,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic                 memReady,
    output logic                 stage1,
    output logic                 stage2,
    output logic                 stage3,
    output logic                 stage4,
    output logic                 stage5,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instrCount,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  taken_q, taken_d;
    logic [PC_WIDTH-1:0]   offset_q, offset_d;
    logic [4:0]            stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;

    logic                  mem_req;

    assign mem_req = memRead | memWrite;

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        taken_d  = taken_q;
        offset_d = offset_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // A halting instruction never reaches EXECUTE, so it leaves
                // pc and instrCount untouched.
                if (endProgram) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                // The branch decision is captured here. It is consumed only
                // when WRITEBACK retires the instruction.
                taken_d  = branch & zero;
                offset_d = branchOffset;
`ifdef STAGE_SEQUENCER_MEM_SKIP_EN
                if (mem_req) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
`else
                state_d = S_MEMORY;
`endif
            end
            S_MEMORY: begin
                if (!mem_req || memReady) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                // The offset is two's complement, so a plain modular add
                // covers both forward and backward branches.
                if (taken_q) begin
                    pc_d = pc_q + PC_WIDTH'(1) + offset_q;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
                if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The status outputs are decoded from the next state and registered, so
    // they line up with the state register without a combinational path out.
    always_comb begin
        stage_d  = 5'b00000;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        case (state_d)
            S_FETCH:     begin stage_d = 5'b00001; busy_d = 1'b1; end
            S_DECODE:    begin stage_d = 5'b00010; busy_d = 1'b1; end
            S_EXECUTE:   begin stage_d = 5'b00100; busy_d = 1'b1; end
            S_MEMORY:    begin stage_d = 5'b01000; busy_d = 1'b1; end
            S_WRITEBACK: begin stage_d = 5'b10000; busy_d = 1'b1; end
            S_HALT:      begin halted_d = 1'b1; end
            default:     begin stage_d = 5'b00000; end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            offset_q <= '0;
            stage_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
            offset_q <= offset_d;
            stage_q  <= stage_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign stage1     = stage_q[0];
    assign stage2     = stage_q[1];
    assign stage3     = stage_q[2];
    assign stage4     = stage_q[3];
    assign stage5     = stage_q[4];
    assign pc         = pc_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign instrCount = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// The driver walks a list of instructions. For every clock it drives the
// inputs and pushes the outputs the DUT must show after the next rising edge
// into exp_q. Those outputs come from an abstract model: a stage number plus
// the model pc and count. A monitor pops one entry per cycle and compares.
// Inputs the DUT should ignore in the current stage are randomized.
// CNT_WIDTH is reduced to 4 so that counter saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int PW = 4;
    localparam int CW = 4;
    localparam int VW = 2 + 5 + PW + CW;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, endProgram, branch, zero;
    logic [PW-1:0] branchOffset;
    logic          memRead, memWrite, memReady;
    logic          stage1, stage2, stage3, stage4, stage5;
    logic [PW-1:0] pc;
    logic          busy, halted;
    logic [CW-1:0] instrCount;
    logic [2:0]    state_dbg;

    always #5 clock = ~clock;

    stage_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .endProgram   (endProgram),
        .branch       (branch),
        .zero         (zero),
        .branchOffset (branchOffset),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReady     (memReady),
        .stage1       (stage1),
        .stage2       (stage2),
        .stage3       (stage3),
        .stage4       (stage4),
        .stage5       (stage5),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .instrCount   (instrCount),
        .state_dbg    (state_dbg)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {halted, busy, stage5, stage4, stage3, stage2, stage1, pc, instrCount};

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    int            cyc_n = 0;
    logic [VW-1:0] exp_q[$];
    logic [PW-1:0] m_pc;
    logic [CW-1:0] m_cnt;

    // Stage numbering: 0 idle/reset, 1..5 pipeline stages, 6 halt.
    function automatic logic [VW-1:0] ev(input int st, input logic [PW-1:0] p,
                                         input logic [CW-1:0] c);
        logic [4:0] stg;
        logic       h, b;
        stg = '0;
        if (st >= 1 && st <= 5) stg[st-1] = 1'b1;
        h = (st == 6);
        b = (st >= 1 && st <= 5);
        return {h, b, stg, p, c};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got,
                         input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got{halt,busy,s5..s1,pc,cnt}=%b_%b_%b_%h_%h exp=%b_%b_%b_%h_%h",
                     name, got[VW-1], got[VW-2], got[VW-3 -: 5], got[PW+CW-1 -: PW], got[CW-1:0],
                     exp[VW-1], exp[VW-2], exp[VW-3 -: 5], exp[PW+CW-1 -: PW], exp[CW-1:0]);
        end
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        logic [VW-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d", cyc_n), dut_vec, e);
            end
            cyc_n++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic noise();
        start        = 1'($urandom_range(0, 1));
        endProgram   = 1'($urandom_range(0, 1));
        branch       = 1'($urandom_range(0, 1));
        zero         = 1'($urandom_range(0, 1));
        branchOffset = PW'($urandom);
        memRead      = 1'($urandom_range(0, 1));
        memWrite     = 1'($urandom_range(0, 1));
        memReady     = 1'($urandom_range(0, 1));
    endtask

    // Expect stage st (with the current model pc/count) after the next edge.
    task automatic cyc(input int st);
        exp_q.push_back(ev(st, m_pc, m_cnt));
        @(negedge clock);
    endtask

    task automatic begin_prog(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            noise();
            start = 1'b0;
            cyc(0);
        end
        noise();
        start = 1'b1;
        cyc(1);
    endtask

    // Called while the DUT is in FETCH. Ends in FETCH of the next instruction,
    // or in HALT / reset.
    task automatic instr(input logic endp, input logic br, input logic zr,
                         input logic [PW-1:0] off, input logic rd, input logic wr,
                         input int waits, input logic abort);
        logic taken;
        logic skip_mem;
        taken = br & zr;
        noise();
        cyc(2);                                   // FETCH -> DECODE
        noise();
        endProgram = endp;
        if (endp) begin
            cyc(6);                               // DECODE -> HALT
        end else begin
            cyc(3);                               // DECODE -> EXECUTE
            noise();
            branch       = br;
            zero         = zr;
            branchOffset = off;
            memRead      = rd;
            memWrite     = wr;
            if (abort) begin
                reset_n = 1'b0;
                m_pc    = '0;
                m_cnt   = '0;
                #1;
                check("async_reset", dut_vec, ev(0, '0, '0));
                cyc(0);
            end else begin
`ifdef STAGE_SEQUENCER_MEM_SKIP_EN
                skip_mem = !(rd | wr);
`else
                skip_mem = 1'b0;
`endif
                if (skip_mem) begin
                    cyc(5);                       // EXECUTE -> WRITEBACK
                end else begin
                    cyc(4);                       // EXECUTE -> MEMORY
                    if (rd | wr) begin
                        for (int k = 0; k < waits; k++) begin
                            noise();
                            memRead  = rd;
                            memWrite = wr;
                            memReady = 1'b0;
                            cyc(4);
                        end
                        noise();
                        memRead  = rd;
                        memWrite = wr;
                        memReady = 1'b1;
                    end else begin
                        noise();
                        memRead  = 1'b0;
                        memWrite = 1'b0;
                    end
                    cyc(5);                       // MEMORY -> WRITEBACK
                end
                noise();
                m_pc = m_pc + PW'(1) + (taken ? off : PW'(0));
                if (m_cnt != '1) m_cnt = m_cnt + CW'(1);
                cyc(1);                           // WRITEBACK -> FETCH
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] off;
        reset_n = 1'b0;
        start = 0; endProgram = 0; branch = 0; zero = 0; branchOffset = '0;
        memRead = 0; memWrite = 0; memReady = 0;
        m_pc = '0;
        m_cnt = '0;
        @(negedge clock);

        // Held in reset: start must not matter.
        noise(); start = 1'b1; cyc(0);
        noise(); cyc(0);

        // Start is sampled on the first edge after release.
        reset_n = 1'b1;
        noise(); start = 1'b1; cyc(1);

        // Plain instructions: pc 0 -> 1 -> 2.
        instr(0, 0, 0, '0, 0, 0, 0, 0);
        instr(0, 0, 0, '0, 0, 0, 0, 0);
        // Taken branch +3 at pc=2 -> 6; backward branch -5 -> 2; not taken -> 3.
        instr(0, 1, 1, 4'd3, 0, 0, 0, 0);
        instr(0, 1, 1, 4'hB, 0, 0, 0, 0);
        instr(0, 1, 0, 4'd3, 0, 0, 0, 0);
        // Memory waits.
        instr(0, 0, 0, '0, 1, 0, 3, 0);
        instr(0, 0, 0, '0, 0, 1, 1, 0);
        instr(0, 0, 0, '0, 1, 1, 0, 0);

        // Random instructions; the count saturates at 15 along the way.
        for (int i = 0; i < 30; i++) begin
            instr(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 0);
        end

        // Land on pc=15, then wrap to 0 with no branch.
        off = 4'd14 - m_pc;
        instr(0, 1, 1, off, 0, 0, 0, 0);
        instr(0, 0, 0, '0, 0, 0, 0, 0);

        // Reset during EXECUTE, then restart from pc=0.
        instr(0, 1, 1, 4'd5, 1, 0, 0, 1);
        noise(); cyc(0);
        reset_n = 1'b1;
        begin_prog(2);
        instr(0, 0, 0, '0, 0, 0, 0, 0);
        instr(0, 0, 0, '0, 1, 0, 2, 0);

        // Halt: pc and count frozen, start ignored.
        instr(1, 0, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            noise(); start = 1'b1; cyc(6);
        end

        @(posedge clock);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d entries left exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
